// File: rtl/chase_if.sv
// Pin bundle for the chase sequencer: raw buttons and mode in, decoder select and status out.
// Plain levels sampled on clk; there is no handshake on any of these signals.
interface chase_if;
  logic       btn_run;
  logic       btn_dir;
  logic       mode;
  logic [3:0] swt;
  logic [2:0] g;
  logic       running;
  logic       dir;

  modport master (
    output btn_run, btn_dir, mode,
    input  swt, g, running, dir
  );

  modport slave (
    input  btn_run, btn_dir, mode,
    output swt, g, running, dir
  );
endinterface

// File: rtl/chase_sequencer.sv
// Debounced run/dir buttons drive a wrap/bounce 4-bit chase code for a 4-to-16 decoder.
// Press-to-action latency is 2 sync + DB_CYCLES + 1 cycles; swt moves 1 cycle after step; no backpressure.
module chase_sequencer #(
  parameter int unsigned STEP_DIV  = 25000000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input logic    clk,
  input logic    rst_n,
  chase_if.slave bus
);

  localparam int unsigned PSW = $clog2(STEP_DIV);
  localparam int unsigned DBW = $clog2(DB_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Bit 0 is the run button, bit 1 the direction button.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     db_lvl;
  logic [1:0]     db_lvl_q;
  logic [1:0]     press;
  logic [DBW-1:0] db_cnt [2];

  state_t         state;
  state_t         state_nxt;
  logic [PSW-1:0] presc;
  logic [PSW-1:0] presc_nxt;
  logic           step;
  logic           flip;
  logic           run_pulse;
  logic           dir_pulse;
  logic [3:0]     swt_q;
  logic [3:0]     swt_nxt;
  logic           dir_q;
  logic           dir_nxt;
  logic [2:0]     g_q;
  logic           running_q;

  assign btn_raw = {bus.btn_dir, bus.btn_run};

  // A level is accepted only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 2'b00;
      sync2    <= 2'b00;
      db_lvl   <= 2'b00;
      db_lvl_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      db_lvl_q <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign press     = db_lvl & ~db_lvl_q;
  assign run_pulse = press[0];
  assign dir_pulse = press[1];

  assign step = (state == RUN) && (presc == PSW'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      swt_q     <= 4'd0;
      dir_q     <= 1'b0;
      g_q       <= 3'b000;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      swt_q     <= swt_nxt;
      dir_q     <= dir_nxt;
      g_q       <= (state_nxt == IDLE) ? 3'b000 : 3'b001;
      running_q <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    swt_nxt   = swt_q;
    flip      = 1'b0;

    case (state)
      IDLE: begin
        presc_nxt = '0;
        if (run_pulse) state_nxt = RUN;
      end
      RUN: begin
        presc_nxt = step ? '0 : presc + PSW'(1);
        if (run_pulse) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (run_pulse) state_nxt = RUN;
      end
      default: begin
        state_nxt = IDLE;
        presc_nxt = '0;
      end
    endcase

    // The step always uses the pre-edge direction; a bounce reverses it afterwards.
    if (step) begin
      if (!dir_q) begin
        if (bus.mode && swt_q == 4'd15) begin
          swt_nxt = 4'd14;
          flip    = 1'b1;
        end else begin
          swt_nxt = swt_q + 4'd1;
        end
      end else begin
        if (bus.mode && swt_q == 4'd0) begin
          swt_nxt = 4'd1;
          flip    = 1'b1;
        end else begin
          swt_nxt = swt_q - 4'd1;
        end
      end
    end

    dir_nxt = dir_q ^ dir_pulse ^ flip;
  end

  assign bus.swt     = swt_q;
  assign bus.g       = g_q;
  assign bus.running = running_q;
  assign bus.dir     = dir_q;

endmodule

// File: tb/tb_chase_sequencer.sv
// Bench for chase_sequencer with small STEP_DIV/DB_CYCLES, checked against a behavioural model.
module tb_chase_sequencer;
  localparam int SD  = 4;
  localparam int DB  = 3;
  localparam int LAT = DB + 3;  // raw button rise before edge 1 -> FSM/dir acts at edge LAT

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  chase_if bus ();

  chase_sequencer #(.STEP_DIV(SD), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] dut_vec;
  assign dut_vec = {bus.swt, bus.g, bus.running, bus.dir};

  // Model: state 0=idle 1=run 2=pause; m_n counts run cycles since leaving idle.
  int m_st, m_n, m_swt;
  bit m_dir, m_db_run, m_db_dir, m_pend_run, m_pend_dir;
  bit q_run[$];
  bit q_dir[$];

  task automatic model_reset();
    m_st = 0; m_n = 0; m_swt = 0; m_dir = 0;
    m_db_run = 0; m_db_dir = 0; m_pend_run = 0; m_pend_dir = 0;
    q_run.delete(); q_dir.delete();
    for (int i = 0; i < DB + 2; i++) begin
      q_run.push_back(1'b0);
      q_dir.push_back(1'b0);
    end
  endtask

  // q[k] is the raw level k+1 edges ago; the synchronised window is raw from 2..DB+1 edges ago.
  function automatic bit settles(input bit q[$], input bit lvl);
    for (int i = 1; i <= DB; i++) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [8:0] model_vec();
    return {4'(m_swt), (m_st != 0) ? 3'b001 : 3'b000, (m_st == 1), m_dir};
  endfunction

  // Advance the model across the coming edge, then wait for it and step just past it.
  task automatic tick();
    bit rp, dp, stp, flp, nr, nd;
    if (!rst_n) begin
      model_reset();
    end else begin
      rp = m_pend_run; dp = m_pend_dir; nr = 0; nd = 0;
      if (settles(q_run, m_db_run)) begin m_db_run = !m_db_run; nr = m_db_run; end
      if (settles(q_dir, m_db_dir)) begin m_db_dir = !m_db_dir; nd = m_db_dir; end
      m_pend_run = nr; m_pend_dir = nd;
      q_run.push_front(bus.btn_run); void'(q_run.pop_back());
      q_dir.push_front(bus.btn_dir); void'(q_dir.pop_back());
      stp = (m_st == 1) && (m_n % SD == SD - 1);
      if (m_st == 1) m_n++;
      flp = 0;
      if (stp) begin
        if (!m_dir) begin
          if (bus.mode && m_swt == 15) begin m_swt = 14; flp = 1; end
          else m_swt = (m_swt + 1) % 16;
        end else begin
          if (bus.mode && m_swt == 0) begin m_swt = 1; flp = 1; end
          else m_swt = (m_swt + 15) % 16;
        end
      end
      m_dir = m_dir ^ dp ^ flp;
      if (rp) m_st = (m_st == 1) ? 2 : 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.btn_run = 1'b0; bus.btn_dir = 1'b0; bus.mode = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic press(input bit is_dir);
    if (is_dir) bus.btn_dir = 1'b1; else bus.btn_run = 1'b1;
    repeat (LAT) tick();
    if (is_dir) bus.btn_dir = 1'b0; else bus.btn_run = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic test_reset();
    bus.btn_run = 1'b0; bus.btn_dir = 1'b0; bus.mode = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.swt !== 4'd0) $display("FAIL reset_swt: got %0d, want 0", bus.swt); else n_pass++;
    n_checks++; if (bus.g !== 3'b000) $display("FAIL reset_g: got %b, want 000", bus.g); else n_pass++;
    n_checks++; if (bus.running !== 1'b0) $display("FAIL reset_running: got %b, want 0", bus.running); else n_pass++;
    n_checks++; if (bus.dir !== 1'b0) $display("FAIL reset_dir: got %b, want 0", bus.dir); else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) $display("FAIL reset_idle cyc %0d: got %h, want %h", i, dut_vec, model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_run_press();
    int e0, rises;
    logic prev;
    logic [3:0] sw[24];
    e0 = -1; rises = 0; prev = 1'b0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      bus.btn_run = (i < 10);
      tick();
      sw[i] = bus.swt;
      if (bus.running && !prev) begin rises++; if (e0 < 0) e0 = i; end
      prev = bus.running;
      n_checks++;
      if (dut_vec !== model_vec()) $display("FAIL run_press cyc %0d: got %h, want %h", i, dut_vec, model_vec());
      else n_pass++;
    end
    n_checks++; if (rises !== 1) $display("FAIL run_press_rises: got %0d, want 1", rises); else n_pass++;
    n_checks++; if (e0 !== LAT - 1) $display("FAIL run_press_latency: got %0d, want %0d", e0, LAT - 1); else n_pass++;
    n_checks++;
    if (bus.g !== 3'b001 || bus.running !== 1'b1) $display("FAIL run_press_state: got g=%b run=%b, want 001/1", bus.g, bus.running);
    else n_pass++;
    n_checks++;
    if (sw[LAT + 2] !== 4'd0 || sw[LAT + 3] !== 4'd1 || sw[LAT + 7] !== 4'd2)
      $display("FAIL run_press_steps: got %0d,%0d,%0d, want 0,1,2", sw[LAT + 2], sw[LAT + 3], sw[LAT + 7]);
    else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.btn_run = (i < 2) || (i >= 4 && i < 6);
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) $display("FAIL glitch cyc %0d: got %h, want %h", i, dut_vec, model_vec());
      else n_pass++;
    end
    n_checks++;
    if (bus.running !== 1'b0 || bus.g !== 3'b000 || bus.swt !== 4'd0)
      $display("FAIL glitch_idle: got run=%b g=%b swt=%0d, want 0/000/0", bus.running, bus.g, bus.swt);
    else n_pass++;
  endtask

  task automatic test_wrap_bounce();
    bit hit;
    do_reset();
    press(1'b0);
    press(1'b1);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      hit = (m_st == 1 && m_swt == 0 && m_dir && m_n % SD == SD - 1);
      if (!hit) tick();
    end
    n_checks++;
    if (!hit || dut_vec !== model_vec()) $display("FAIL wrap_pre: reached=%b got %h, want %h", hit, dut_vec, model_vec());
    else n_pass++;
    tick();
    n_checks++;
    if (bus.swt !== 4'd15 || bus.dir !== 1'b1) $display("FAIL wrap_down: got swt=%0d dir=%b, want 15/1", bus.swt, bus.dir);
    else n_pass++;

    bus.mode = 1'b1;
    press(1'b1);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      hit = (m_st == 1 && m_swt == 15 && !m_dir && m_n % SD == SD - 1);
      if (!hit) tick();
    end
    n_checks++;
    if (!hit || dut_vec !== model_vec()) $display("FAIL bounce_pre: reached=%b got %h, want %h", hit, dut_vec, model_vec());
    else n_pass++;
    tick();
    n_checks++;
    if (bus.swt !== 4'd14 || bus.dir !== 1'b1) $display("FAIL bounce_top: got swt=%0d dir=%b, want 14/1", bus.swt, bus.dir);
    else n_pass++;
  endtask

  // Continues from test_wrap_bounce: bounce mode, running, counting down.
  task automatic test_flip_cancel();
    int dist_t, swt_t;
    bit hit;
    dist_t = ((LAT - 1) % SD) + 1;
    swt_t  = (LAT - dist_t) / SD;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      hit = (m_st == 1 && m_dir && m_swt == swt_t && (SD - m_n % SD) == dist_t);
      if (!hit) tick();
    end
    n_checks++;
    if (!hit || dut_vec !== model_vec()) $display("FAIL cancel_pre: reached=%b got %h, want %h", hit, dut_vec, model_vec());
    else n_pass++;
    bus.btn_dir = 1'b1;
    repeat (LAT) tick();
    n_checks++;
    if (bus.swt !== 4'd1 || bus.dir !== 1'b1) $display("FAIL cancel: got swt=%0d dir=%b, want 1/1", bus.swt, bus.dir);
    else n_pass++;
    bus.btn_dir = 1'b0;
    repeat (LAT) tick();
    n_checks++;
    if (dut_vec !== model_vec()) $display("FAIL cancel_after: got %h, want %h", dut_vec, model_vec());
    else n_pass++;
  endtask

  task automatic test_pause_resume();
    int dist_t, swt_t;
    bit hit;
    dist_t = ((LAT - 2) % SD) + 1;
    swt_t  = 7 - ((LAT - 1 - dist_t) / SD + 1);
    do_reset();
    press(1'b0);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      hit = (m_st == 1 && !m_dir && m_swt == swt_t && (SD - m_n % SD) == dist_t);
      if (!hit) tick();
    end
    n_checks++;
    if (!hit || dut_vec !== model_vec()) $display("FAIL pause_pre: reached=%b got %h, want %h", hit, dut_vec, model_vec());
    else n_pass++;
    bus.btn_run = 1'b1;
    repeat (LAT) tick();
    n_checks++;
    if (bus.running !== 1'b0 || bus.swt !== 4'd7 || bus.g !== 3'b001)
      $display("FAIL pause_enter: got run=%b swt=%0d g=%b, want 0/7/001", bus.running, bus.swt, bus.g);
    else n_pass++;
    bus.btn_run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (bus.swt !== 4'd7 || bus.g !== 3'b001 || bus.running !== 1'b0)
        $display("FAIL pause_hold cyc %0d: got swt=%0d g=%b run=%b, want 7/001/0", i, bus.swt, bus.g, bus.running);
      else n_pass++;
    end
    bus.btn_run = 1'b1;
    repeat (LAT) tick();
    n_checks++;
    if (bus.running !== 1'b1 || bus.swt !== 4'd7) $display("FAIL resume: got run=%b swt=%0d, want 1/7", bus.running, bus.swt);
    else n_pass++;
    tick(); tick();
    n_checks++; if (bus.swt !== 4'd7) $display("FAIL resume_wait: got %0d, want 7", bus.swt); else n_pass++;
    tick();
    n_checks++; if (bus.swt !== 4'd8) $display("FAIL resume_step: got %0d, want 8", bus.swt); else n_pass++;
    bus.btn_run = 1'b0;
    repeat (LAT) tick();
    n_checks++;
    if (dut_vec !== model_vec()) $display("FAIL resume_after: got %h, want %h", dut_vec, model_vec());
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit hit;
    do_reset();
    press(1'b0);
    press(1'b1);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      hit = (m_st == 1 && m_swt == 9);
      if (!hit) tick();
    end
    n_checks++;
    if (!hit || dut_vec !== model_vec()) $display("FAIL midrst_pre: reached=%b got %h, want %h", hit, dut_vec, model_vec());
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.swt !== 4'd0 || bus.g !== 3'b000 || bus.dir !== 1'b0 || bus.running !== 1'b0)
      $display("FAIL midrst_async: got swt=%0d g=%b dir=%b run=%b, want 0/000/0/0", bus.swt, bus.g, bus.dir, bus.running);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (bus.running !== 1'b0 || bus.swt !== 4'd0 || bus.g !== 3'b000)
        $display("FAIL midrst_idle cyc %0d: got run=%b swt=%0d g=%b, want 0/0/000", i, bus.running, bus.swt, bus.g);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int run_left, dir_left;
    run_left = 0; dir_left = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        bus.btn_run = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 2 * LAT);
      end
      if (dir_left == 0) begin
        bus.btn_dir = 1'($urandom_range(0, 1));
        dir_left = $urandom_range(1, 3 * LAT);
      end
      run_left--;
      dir_left--;
      if ($urandom_range(0, 99) == 0) bus.mode = ~bus.mode;
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) $display("FAIL random cyc %0d: got %h, want %h", c, dut_vec, model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_run_press();
    test_glitch();
    test_wrap_bounce();
    test_flip_cancel();
    test_pause_resume();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, %0d checks made", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/chase_sequencer.md
CHASE_SEQUENCER -- requirements
Module: chase_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter STEP_DIV SHALL default to 25000000 and set the clk cycles per code step (minimum 2).
REQ-003 Parameter DB_CYCLES SHALL default to 1000000 and set the consecutive stable cycles required to accept a button level (minimum 2).
REQ-004 Port clk  input  1  rising-edge system clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port btn_run  input  1  raw, asynchronous push button; each press toggles run/pause.
REQ-007 Port btn_dir  input  1  raw, asynchronous push button; each press toggles direction.
REQ-008 Port mode  input  1  synchronous level: 0 = wrap, 1 = bounce.
REQ-009 Port swt  output  4  code driven to the downstream 4-to-16 decoder select.
REQ-010 Port g  output  3  decoder enable group: 3'b001 = enabled, 3'b000 = blanked.
REQ-011 Port running  output  1  high only in state RUN.
REQ-012 Port dir  output  1  0 = counting up, 1 = counting down.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 The debounced level SHALL update only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any reversion SHALL restart the count.
REQ-015 A debounced 0->1 transition SHALL produce exactly one single-cycle press pulse; release SHALL produce no pulse.
REQ-016 The FSM SHALL have three states: IDLE (reset state), RUN and PAUSE.
REQ-017 FSM transitions SHALL be: IDLE->RUN, RUN->PAUSE and PAUSE->RUN on a run pulse; there is no other transition except reset.
REQ-018 The prescaler SHALL count 0..STEP_DIV-1 only in RUN, hold in PAUSE, and read 0 in IDLE.
REQ-019 The prescaler SHALL assert step for one cycle when it reaches STEP_DIV-1, then wrap to 0.
REQ-020 On step, swt SHALL update at the next clk edge: +1 if dir=0, -1 if dir=1 (registered, 1-cycle latency).
REQ-021 mode=0: swt SHALL wrap 15->0 going up and 0->15 going down; dir SHALL be unchanged by the step.
REQ-022 mode=1: going up at 15 SHALL give swt=14 and flip dir to 1; going down at 0 SHALL give swt=1 and flip dir to 0.
REQ-023 A dir pulse SHALL toggle dir in every state, including IDLE.
REQ-024 When a dir pulse coincides with a bounce flip, dir_next SHALL equal dir ^ pulse ^ flip, and the step itself SHALL use the pre-edge dir.
REQ-025 A run pulse coinciding with step in RUN SHALL apply the step and enter PAUSE in the same edge.
REQ-026 g SHALL be 3'b001 in RUN and PAUSE and 3'b000 in IDLE; in PAUSE, swt SHALL hold.
REQ-027 A change of mode SHALL take effect at the next step only; swt SHALL not be altered at the time of the change.
REQ-028 All outputs SHALL be driven directly from flops (no combinational path from inputs).

Reset
REQ-029 While rst_n=0, outputs SHALL immediately read: swt=0, g=3'b000, running=0, dir=0.
REQ-030 Asserting rst_n=0 SHALL also clear the FSM to IDLE and clear the prescaler, debounce counters, debounced levels and synchronizers to 0, mid-operation included.
REQ-031 After rst_n deasserts, the first press SHALL be recognized only after synchronization plus DB_CYCLES of stable input.

Verification (STEP_DIV=4, DB_CYCLES=3)
REQ-032 Reset then btn_run high for 10 cycles -> exactly one run pulse; g=3'b001, running=1; swt steps 0,1,2 every 4 cycles.
REQ-033 btn_run glitches high 2 cycles, low, high 2 cycles -> no pulse; state stays IDLE, g=3'b000.
REQ-034 mode=0, dir=1, swt=0, step -> swt=15, dir=1; mode=1, dir=0, swt=15, step -> swt=14, dir=1.
REQ-035 mode=1, swt=0, dir=1, dir pulse on the same cycle as step -> swt=1, dir=1 (flip and toggle cancel).
REQ-036 RUN at swt=7, run pulse -> PAUSE, swt holds at 7 for 20 cycles with g=3'b001; second pulse -> resumes, next step 3 cycles later if the prescaler stopped at 1.
REQ-037 rst_n pulsed low mid-RUN at swt=9 -> same-cycle swt=0, g=3'b000, dir=0; after release, the block stays IDLE with no stepping.
